ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage; sits beside the single-cycle EX ALU and owns the HI/LO registers.
- Accepts MDU ops from the EX-stage instruction and models fixed multiply/divide latency with a busy counter.
- Produces the stall request for the hazard unit and the mfhi/mflo read value.
- Honours a flush from the exception path so that no cancelled op commits.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
mdu_op  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo (9-12 optional)
start  input  1  EX instruction is valid and issues mdu_op this cycle
flush  input  1  exception/flush from a later stage; cancels issue and any pending op
src_a  input  WIDTH  rs operand (dividend / multiplicand / mthi/mtlo data)
src_b  input  WIDTH  rt operand
busy  output  1  multi-cycle op in progress
stall  output  1  freeze request to the hazard unit
done  output  1  one-cycle pulse when HI/LO are committed by mult/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
mdu_res  output  WIDTH  combinational read value: hi for mfhi, lo for mflo, else 0

Behaviour:
- Reset (async, rst_n=0) clears hi, lo, busy, done, the counter and the pending result registers. Reset mid-operation discards the op.
- An issue occurs when start=1, flush=0 and busy=0.
- Mult/div issue:
  - The full result is computed from src_a/src_b and latched into pending hi/lo.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle, for exactly that many cycles.
  - On the edge ending the last busy cycle: hi/lo take the pending values, busy->0, and done=1 for one cycle.
- Mthi/mtlo issue: hi (or lo) <= src_a on the same edge. busy is not raised and done is not pulsed.
- Mfhi/mflo: mdu_res reflects the current hi/lo combinationally. Same-cycle writes are not forwarded.
- stall = start & (mdu_op != 0) & busy. The issuing instruction itself never stalls.
- start with busy=1: ignored, with stall asserted. Issue happens in the first cycle busy=0.
- flush=1:
  - Suppresses any issue that cycle.
  - If busy, aborts on that edge: busy->0, counter cleared, hi/lo unchanged, no done.
  - flush has priority over completion in the same cycle.
- Unsigned ops: operands are zero-extended. Signed ops: operands are sign-extended.
- Multiply: {hi,lo} = full 2*WIDTH-bit product.
- Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Divide by zero (div and divu): hi = src_a, lo = all ones.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- The counter is sized as $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Unused op codes are a no-op.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, ops 9 madd, 10 maddu, 11 msub and 12 msubu are enabled:
  - {hi,lo} +/-= product (signed/unsigned), modulo 2^(2*WIDTH).
  - The hi/lo values used are those current at issue; latency is MULT_CYCLES.
  - Completion, stall and flush rules are the same as mult.
- When not defined, codes 9-12 are no-ops with no state change.

Test Plan:
1. mult src_a=0xFFFFFFFD, src_b=7 -> busy for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB and a one-cycle done pulse. multu with the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
2. divu 100/7 -> lo=14, hi=2 after 10 busy cycles. An mflo issued on busy cycle 2 keeps stall=1 until busy falls, then reads mdu_res=14.
3. div boundary values:
   - div 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - div 5/0 -> hi=5, lo=0xFFFFFFFF.
   - div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Flush cases:
   - div started with hi=lo=0x11; flush on busy cycle 3 -> busy=0 next cycle, hi=lo=0x11, no done.
   - flush together with start -> no issue.
5. Writes and reset:
   - mthi 0x1234 -> next cycle mfhi gives mdu_res=0x1234 with stall=0.
   - rst_n low mid-mult -> hi=lo=0, busy=0 immediately.
6. With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu 1*1 -> hi=1, lo=0. Without MDU_MADD_EN: same op leaves hi/lo unchanged with busy=0.

Source files
------------

// File: rtl/ex_mdu.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (op codes 9-12).
module ex_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       mdu_op,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mdu_res
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: an op issues when start=1, flush=0 and busy=0. While busy,
  // a start with a non-zero op is held off by stall and re-presented until
  // busy drops; flush cancels both the presented op and any op in flight.
  logic issue;
  assign issue = start & ~flush & ~busy;
  assign stall = start & (mdu_op != OP_NONE) & busy;

  logic is_signed, is_mul, is_div, is_acc, is_sub;

  always_comb begin
    is_signed = 1'b0;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_acc    = 1'b0;
    is_sub    = 1'b0;
    case (mdu_op)
      OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_acc = 1'b1; is_signed = 1'b1; end
      OP_MADDU: is_acc = 1'b1;
      OP_MSUB:  begin is_acc = 1'b1; is_sub = 1'b1; is_signed = 1'b1; end
      OP_MSUBU: begin is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Low 2*WIDTH bits of the extended product are right for both signednesses.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc_res;
  assign ext_a   = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign ext_b   = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign prod    = ext_a * ext_b;
  assign acc_res = is_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, safe_b, uq, ur, div_hi, div_lo;

  always_comb begin
    neg_a  = is_signed & src_a[WIDTH-1];
    neg_b  = is_signed & src_b[WIDTH-1];
    mag_a  = neg_a ? -src_a : src_a;
    mag_b  = neg_b ? -src_b : src_b;
    safe_b = (src_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    uq     = mag_a / safe_b;
    ur     = mag_a % safe_b;
    if (src_b == '0) begin
      div_hi = src_a;
      div_lo = '1;
    end else if (is_signed && src_a == MOST_NEG && src_b == '1) begin
      div_hi = '0;
      div_lo = MOST_NEG;
    end else begin
      div_hi = neg_a ? -ur : ur;
      div_lo = (neg_a ^ neg_b) ? -uq : uq;
    end
  end

  logic [2*WIDTH-1:0] result;
  assign result = is_div ? {div_hi, div_lo} : (is_acc ? acc_res : prod);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (busy) begin
        if (cnt == CW'(1)) begin
          hi   <= pend_hi;
          lo   <= pend_lo;
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end else if (issue) begin
        if (is_mul || is_div || is_acc) begin
          pend_hi <= result[2*WIDTH-1:WIDTH];
          pend_lo <= result[WIDTH-1:0];
          cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
          busy    <= 1'b1;
        end else if (mdu_op == OP_MTHI) begin
          hi <= src_a;
        end else if (mdu_op == OP_MTLO) begin
          lo <= src_a;
        end
      end
    end
  end

  // Reads see the registered HI/LO only; a same-cycle write is not forwarded.
  always_comb begin
    mdu_res = '0;
    if (mdu_op == OP_MFHI)      mdu_res = hi;
    else if (mdu_op == OP_MFLO) mdu_res = lo;
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed scenarios plus randomized ops
// checked against an arithmetic reference model (honours MDU_MADD_EN).
module tb_ex_mdu;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   mdu_op = '0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo, mdu_res;

  int           chk_cnt = 0;
  int           fail_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  ex_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .mdu_op(mdu_op), .start(start), .flush(flush),
    .src_a(src_a), .src_b(src_b), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo), .mdu_res(mdu_res)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: {hi,lo} after the op, from plain language arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] h,
                                             input logic [W-1:0] l);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return {32'b0, a} * {32'b0, b};
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd7: return {a, l};
      4'd8: return {h, a};
`ifdef MDU_MADD_EN
      4'd9:  return {h, l} + 64'(sa * sb);
      4'd10: return {h, l} + {32'b0, a} * {32'b0, b};
      4'd11: return {h, l} - 64'(sa * sb);
      4'd12: return {h, l} - {32'b0, a} * {32'b0, b};
`endif
      default: return {h, l};
    endcase
  endfunction

  function automatic int op_cycles(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return MC;
      4'd3, 4'd4: return DC;
`ifdef MDU_MADD_EN
      4'd9, 4'd10, 4'd11, 4'd12: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom());
    endcase
  endfunction

  // driver: issue one op (entered at posedge+1 with busy=0) and follow it to completion
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0]  r;
    logic [W-1:0] eh, el;
    int           n;
    r = ref_result(op, a, b, m_hi, m_lo);
    n = op_cycles(op);
    exp_q.push_back(r[63:32]);
    exp_q.push_back(r[31:0]);
    start = 1'b1; mdu_op = op; src_a = a; src_b = b;
    @(negedge clk);
    check_eq("issue_stall", stall, 1'b0);
    if (op == 4'd5)      check_eq("mfhi_res", mdu_res, m_hi);
    else if (op == 4'd6) check_eq("mflo_res", mdu_res, m_lo);
    else                 check_eq("res_zero", mdu_res, '0);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("busy_high", busy, 1'b1);
      check_eq("done_early", done, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("busy_low", busy, 1'b0);
    check_eq("done_pulse", done, (n > 0) ? 1'b1 : 1'b0);
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    check_eq("hi", hi, eh);
    check_eq("lo", lo, el);
    m_hi = eh; m_lo = el;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("done_fall", done, 1'b0);
    @(posedge clk); #1;
  endtask

  logic [3:0] ops[12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

  initial begin
    int  waited;
    bit  saw_done;
    #3;
    check_eq("rst_hi", hi, '0);
    check_eq("rst_lo", lo, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // signed / unsigned multiply
    run_op(4'd1, 32'hFFFF_FFFD, 32'd7);
    check_eq("mult_hi_const", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo_const", lo, 32'hFFFF_FFEB);
    run_op(4'd2, 32'hFFFF_FFFD, 32'd7);
    check_eq("multu_hi_const", hi, 32'h0000_0006);

    // divu with an mflo waiting behind it
    start = 1'b1; mdu_op = 4'd4; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = '0;
    @(posedge clk); #1;
    start = 1'b1; mdu_op = 4'd6;
    waited = 0;
    while (waited < 20) begin
      @(negedge clk);
      if (!busy) break;
      check_eq("mflo_stall", stall, 1'b1);
      waited++;
      @(posedge clk); #1;
    end
    check_eq("stall_cycles", waited, 9);
    check_eq("mflo_after_stall", stall, 1'b0);
    check_eq("mflo_after_res", mdu_res, 32'd14);
    check_eq("divu_done", done, 1'b1);
    check_eq("divu_hi", hi, 32'd2);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = '0;
    m_hi = 32'd2; m_lo = 32'd14;

    // divide boundaries
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    run_op(4'd3, 32'd5, 32'd0);
    check_eq("div_zero_lo_const", lo, 32'hFFFF_FFFF);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("div_ovf_lo_const", lo, 32'h8000_0000);

    // flush on busy cycle 3
    run_op(4'd7, 32'h11, '0);
    run_op(4'd8, 32'h11, '0);
    start = 1'b1; mdu_op = 4'd3; src_a = 32'd50; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_busy_before", busy, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy_after", busy, 1'b0);
    check_eq("flush_hi", hi, 32'h11);
    check_eq("flush_lo", lo, 32'h11);
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_eq("flush_no_done", saw_done, 1'b0);

    // flush together with start
    start = 1'b1; flush = 1'b1; mdu_op = 4'd1; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; mdu_op = '0;
    @(negedge clk);
    check_eq("flush_start_busy", busy, 1'b0);
    check_eq("flush_start_lo", lo, 32'h11);
    @(posedge clk); #1;

    // mthi then mfhi
    run_op(4'd7, 32'h1234, '0);
    run_op(4'd5, '0, '0);

    // reset in the middle of a mult
    run_op(4'd1, 32'h1234_5678, 32'h10);
    start = 1'b1; mdu_op = 4'd1; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_hi", hi, '0);
    check_eq("midrst_lo", lo, '0);
    check_eq("midrst_busy", busy, 1'b0);
    #2 rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;

    // maddu (or no-op when the accumulate ops are compiled out)
    run_op(4'd7, '0, '0);
    run_op(4'd8, 32'hFFFF_FFFF, '0);
    run_op(4'd10, 32'd1, 32'd1);

    // randomized ops against the model
    for (int k = 0; k < 40; k++) begin
      run_op(ops[$urandom_range(0, 11)], rand_val(), rand_val());
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
